// File: rtl/axi_sub_pkg.sv
// Shared constants and FSM state types for the AXI4 memory subordinate.
package axi_sub_pkg;

    localparam int BEAT_BYTES = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/axi_sub_ram.sv
// One-write/one-read synchronous RAM with byte strobes; a same-edge read
// returns the contents from before that edge's write.
module axi_sub_ram #(
    parameter int WORDS  = 512,
    parameter int DATA_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic [$clog2(WORDS)-1:0]  waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [DATA_W/8-1:0]       wstrb_i,
    input  logic                      re_i,
    input  logic [$clog2(WORDS)-1:0]  raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array is deliberately left out of reset so contents
    // survive ARESETn and the array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < LANES; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // NOTE: non-blocking assignments make this read sample the array before
    // the write above lands, which is what gives read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_mem_subordinate.sv
// AXI4 subordinate mapping a MEM_BYTES RAM at address 0: single-beat writes,
// INCR read bursts, DECERR for anything at or above MEM_BYTES.
module axi4_mem_subordinate
    import axi_sub_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int WORDS  = MEM_BYTES / BEAT_BYTES;
    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam int LSB    = $clog2(BEAT_BYTES);

    // ---------------- write channel ----------------
    w_state_t          w_state_q, w_state_d;
    logic              w_hs, aw_in_range;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;

    assign aw_in_range = AWADDR < ADDR_W'(MEM_BYTES);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    // NOTE: every always_comb output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE: if (AWVALID && WVALID) w_state_d = W_RESP;
            W_RESP: if (BREADY)            w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        BVALID  = 1'b0;
        unique case (w_state_q)
            W_IDLE: AWREADY = AWVALID && WVALID;
            W_RESP: BVALID  = 1'b1;
        endcase
    end

    assign WREADY = AWREADY;
    assign w_hs   = AWREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bid_q   <= '0;
            bresp_q <= RESP_OKAY;
        end else if (w_hs) begin
            bid_q   <= AWID;
            bresp_q <= aw_in_range ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign BID   = bid_q;
    assign BRESP = bresp_q;

    // ---------------- read channel ----------------
    r_state_t          r_state_q, r_state_d;
    logic              ar_hs, beat_hs, load, load_in_range;
    logic [ADDR_W-1:0] addr_q, load_addr;
    logic [7:0]        count_q, load_count;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;
    logic [DATA_W-1:0] ram_rdata;

    assign ar_hs   = (r_state_q == R_IDLE) && ARVALID;
    assign beat_hs = (r_state_q == R_DATA) && RREADY && !rlast_q;
    assign load    = ar_hs || beat_hs;

    // Beat address either starts a burst (aligned) or steps one beat on.
    always_comb begin
        load_addr  = addr_q + ADDR_W'(BEAT_BYTES);
        load_count = count_q - 8'd1;
        if (ar_hs) begin
            load_addr  = ARADDR & ~ADDR_W'(BEAT_BYTES - 1);
            load_count = ARLEN;
        end
    end

    assign load_in_range = load_addr < ADDR_W'(MEM_BYTES);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE: if (ARVALID)            r_state_d = R_DATA;
            R_DATA: if (RREADY && rlast_q)  r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        unique case (r_state_q)
            R_IDLE: ARREADY = 1'b1;
            R_DATA: RVALID  = 1'b1;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q  <= '0;
            count_q <= '0;
            rid_q   <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (load) begin
            addr_q  <= load_addr;
            count_q <= load_count;
            rresp_q <= load_in_range ? RESP_OKAY : RESP_DECERR;
            rlast_q <= (load_count == 8'd0);
            if (ar_hs) rid_q <= ARID;
        end
    end

    assign RID   = rid_q;
    assign RRESP = rresp_q;
    assign RLAST = rlast_q;
    assign RDATA = (rresp_q == RESP_OKAY) ? ram_rdata : '0;

    axi_sub_ram #(
        .WORDS  (WORDS),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .we_i    (w_hs && aw_in_range),
        .waddr_i (AWADDR[MEM_AW-1:LSB]),
        .wdata_i (WDATA),
        .wstrb_i (WSTRB),
        .re_i    (load),
        .raddr_i (load_addr[MEM_AW-1:LSB]),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_axi4_mem_subordinate.sv
// Self-checking bench for axi4_mem_subordinate: directed scenarios plus a
// random write/burst mix checked against a word-array memory model.
module tb_axi4_mem_subordinate;

    localparam int MEM_BYTES = 4096;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [3:0]  AWID, BID, ARID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB, ARLEN;
    logic [1:0]  BRESP, RRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

    int n_checks = 0;
    int n_fails  = 0;

    logic [63:0] mem_m [MEM_BYTES/8];

    axi4_mem_subordinate #(
        .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BYTES(MEM_BYTES)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [31:0] a);
        return (a < MEM_BYTES) ? mem_m[a[11:3]] : 64'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return (a < MEM_BYTES) ? 2'b00 : 2'b11;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        if (a < MEM_BYTES)
            for (int b = 0; b < 8; b++)
                if (s[b]) mem_m[a[11:3]][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 32'($urandom_range(0, MEM_BYTES - 1));
            2:       return 32'(MEM_BYTES - 8 * $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [3:0] id, input int bdelay);
        logic [1:0] exp_resp;
        exp_resp = model_resp(addr);
        @(negedge ACLK);
        AWADDR = addr; AWID = id; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        #1;
        check("awready_idle", AWREADY, 1);
        check("wready_idle", WREADY, 1);
        @(negedge ACLK);
        check("awready_resp", AWREADY, 0);
        check("bvalid", BVALID, 1);
        check("bid", BID, id);
        check("bresp", BRESP, exp_resp);
        AWVALID = 1'b0; WVALID = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            @(negedge ACLK);
            check("bvalid_hold", BVALID, 1);
            check("bid_hold", BID, id);
            check("bresp_hold", BRESP, exp_resp);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check("bvalid_done", BVALID, 0);
        model_wr(addr, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input int max_stall);
        logic [31:0] a;
        logic [63:0] exp_d;
        int stall;
        @(negedge ACLK);
        ARADDR = addr; ARLEN = len; ARID = id; ARVALID = 1'b1;
        #1;
        check("arready_idle", ARREADY, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        check("arready_busy", ARREADY, 0);
        a = addr & ~32'h7;
        for (int i = 0; i <= int'(len); i++) begin
            exp_d = model_rd(a);
            stall = $urandom_range(0, max_stall);
            RREADY = 1'b0;
            for (int s = 0; s < stall; s++) begin
                check("rvalid_stall", RVALID, 1);
                check("rdata_stall", RDATA, exp_d);
                @(negedge ACLK);
            end
            RREADY = 1'b1;
            check("rvalid", RVALID, 1);
            check("rdata", RDATA, exp_d);
            check("rresp", RRESP, model_resp(a));
            check("rlast", RLAST, (i == int'(len)));
            check("rid", RID, id);
            @(negedge ACLK);
            RREADY = 1'b0;
            a = a + 32'd8;
        end
        check("rvalid_end", RVALID, 0);
        check("arready_end", ARREADY, 1);
    endtask

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(negedge ACLK);

        check("rst_arready", ARREADY, 1);
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_rlast", RLAST, 0);
        check("rst_rdata", RDATA, 0);
        check("rst_rid", RID, 0);
        check("rst_bid", BID, 0);
        check("rst_rresp", RRESP, 0);
        check("rst_bresp", BRESP, 0);
        ARESETn = 1'b1;

        // Give every word a known value so the model covers the whole array.
        for (int i = 0; i < MEM_BYTES / 8; i++)
            do_write(32'(i * 8), {$urandom, $urandom}, 8'hFF, 4'(i), 0);

        do_write(32'h8,   64'hCAFEBAB0F00DFACE, 8'hFF, 4'h3, 1);
        do_write(32'h10,  64'h1122334455667788, 8'hFF, 4'hA, 0);
        do_write(32'hFF8, 64'hBEEFCFFE0000FFFF, 8'hFF, 4'h6, 2);
        do_read(32'h8,   8'd0, 4'h1, 0);
        do_read(32'h10,  8'd0, 4'h2, 0);
        do_read(32'hFF8, 8'd0, 4'h3, 0);
        check("model_8", model_rd(32'h8), 64'hCAFEBAB0F00DFACE);

        do_read(32'h2000, 8'd0, 4'h4, 0);
        do_read(32'hFFFFFFF0, 8'd0, 4'h5, 0);
        do_write(32'h2000, 64'hDEADDEADDEADDEAD, 8'hFF, 4'h7, 0);
        do_read(32'h8, 8'd0, 4'h8, 0);

        do_read(32'hFF0, 8'd2, 4'h9, 0);
        do_read(32'hFFFFFFF8, 8'd1, 4'hB, 0);

        // Write 0x8 while beat 0 of a burst from 0x8 is stalled.
        @(negedge ACLK);
        ARADDR = 32'h8; ARLEN = 8'd1; ARID = 4'hC; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b0;
        AWADDR = 32'h8; AWID = 4'h2; WDATA = 64'h0; WSTRB = 8'hFF;
        AWVALID = 1'b1; WVALID = 1'b1;
        check("stall_rdata0", RDATA, 64'hCAFEBAB0F00DFACE);
        check("stall_rid0", RID, 4'hC);
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        check("stall_bvalid", BVALID, 1);
        check("stall_bresp", BRESP, 2'b00);
        check("stall_rdata1", RDATA, 64'hCAFEBAB0F00DFACE);
        model_wr(32'h8, 64'h0, 8'hFF);
        @(negedge ACLK);
        BREADY = 1'b0;
        check("stall_rdata2", RDATA, 64'hCAFEBAB0F00DFACE);
        check("stall_rvalid", RVALID, 1);
        RREADY = 1'b1;
        check("stall_rlast0", RLAST, 0);
        @(negedge ACLK);
        RREADY = 1'b0;
        for (int s = 0; s < 3; s++) begin
            check("stall_beat1", RDATA, model_rd(32'h10));
            check("stall_rid1", RID, 4'hC);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        check("stall_rlast1", RLAST, 1);
        @(negedge ACLK);
        RREADY = 1'b0;
        check("stall_done", RVALID, 0);
        do_read(32'h8, 8'd0, 4'hD, 1);

        do_write(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 4'h1, 0);
        do_read(32'h10, 8'd0, 4'h2, 0);
        check("model_strb", model_rd(32'h10), 64'h11223344FFFFFFFF);

        // Reset during a burst with a write response outstanding.
        @(negedge ACLK);
        ARADDR = 32'h0; ARLEN = 8'd7; ARID = 4'hE; ARVALID = 1'b1;
        AWADDR = 32'h20; AWID = 4'h9; WDATA = 64'h0123456789ABCDEF; WSTRB = 8'hFF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; RREADY = 1'b1;
        model_wr(32'h20, 64'h0123456789ABCDEF, 8'hFF);
        check("mid_bvalid", BVALID, 1);
        @(negedge ACLK);
        check("mid_rvalid", RVALID, 1);
        ARESETn = 1'b0;
        #1;
        check("mid_rst_rvalid", RVALID, 0);
        check("mid_rst_arready", ARREADY, 1);
        check("mid_rst_bvalid", BVALID, 0);
        check("mid_rst_rlast", RLAST, 0);
        RREADY = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        do_read(32'h10, 8'd0, 4'h3, 0);
        do_read(32'h20, 8'd0, 4'h4, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 0)
                do_write(rand_addr(), {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                         4'($urandom_range(0, 15)), $urandom_range(0, 2));
            else
                do_read(rand_addr(), 8'($urandom_range(0, 5)), 4'($urandom_range(0, 15)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
